// File: rtl/noc_pkg.sv
// Shared definitions for the mesh endpoint NI: flit type codes, head-flit field offsets
// and the TX/RX state encodings.
package noc_pkg;

   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_TAIL   = 2'b01;
   localparam logic [1:0] FLIT_HEAD   = 2'b10;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   localparam int LEN_W = 3;

   // Head layout: type at the top, then len/dy/dx packed from bit 0 upward.
   function automatic int type_lsb(input int ll);
      return ll - 2;
   endfunction

   function automatic int dy_lsb(input int mm);
      return mm;
   endfunction

   function automatic int len_lsb(input int mm);
      return 2 * mm;
   endfunction

   typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY} tx_state_t;
   typedef enum logic {RX_WAIT_HEAD, RX_IN_PKT} rx_state_t;

endpackage

// File: rtl/noc_endpoint_ni_if.sv
// Core-side (cmd/tx/rx) and router-side (inj/ej) handshake bundle of the endpoint NI.
// slave is the NI's view, master is the environment (core + router) view.
interface noc_endpoint_ni_if #(
   parameter int LL = 16,
   parameter int MM = 2
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [MM-1:0] cmd_dx;
   logic [MM-1:0] cmd_dy;
   logic [2:0]    cmd_len;
   logic          tx_valid;
   logic          tx_ready;
   logic [LL-3:0] tx_data;
   logic [LL-1:0] inj_data;
   logic          inj_en;
   logic          inj_ready;
   logic [LL-1:0] ej_data;
   logic          ej_req;
   logic          ej_ans;
   logic          rx_valid;
   logic          rx_ready;
   logic [LL-3:0] rx_data;
   logic          rx_last;

   modport slave (
      input  cmd_valid, cmd_dx, cmd_dy, cmd_len, tx_valid, tx_data,
      input  inj_ready, ej_data, ej_req, rx_ready,
      output cmd_ready, tx_ready, inj_data, inj_en, ej_ans, rx_valid, rx_data, rx_last
   );

   modport master (
      output cmd_valid, cmd_dx, cmd_dy, cmd_len, tx_valid, tx_data,
      output inj_ready, ej_data, ej_req, rx_ready,
      input  cmd_ready, tx_ready, inj_data, inj_en, ej_ans, rx_valid, rx_data, rx_last
   );
endinterface

// File: rtl/ni_eject_fifo.sv
// Synchronous DEPTH x W FIFO, data visible at the front while not empty (zero read latency).
// Writes while full and reads while empty are ignored; DEPTH must be a power of two.
module ni_eject_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;

   // Extra MSB on each pointer separates full from empty when the indices coincide.
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign rd_data = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         mem[wptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en && !full) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_en && !empty) begin
            rptr <= rptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_endpoint_ni.sv
// Mesh endpoint NI: packetises core commands onto the router local input (head 1 cycle after cmd),
// and de-packetises ejected flits to the core; inj waits on inj_ready, eject stalls while the FIFO is full.
module noc_endpoint_ni
   import noc_pkg::*;
#(
   parameter int LL     = 16,
   parameter int MM     = 2,
   parameter int MAXLEN = 4,
   parameter int FDEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [MM-1:0]   my_x,
   input  logic [MM-1:0]   my_y,
   noc_endpoint_ni_if.slave ni,
   output logic            err_misroute
);
   localparam int          TL       = type_lsb(LL);
   localparam int          DY       = dy_lsb(MM);
   localparam int          LN       = len_lsb(MM);
   localparam logic [2:0]  MAXLEN_L = 3'(MAXLEN);

   // ---------------- TX ----------------
   tx_state_t     tx_state, tx_next;
   logic [2:0]    len_q, cnt_q, cmd_len_c;
   logic [LL-1:0] head_q, head_c;
   logic          body_last, body_xfer;

   always_comb begin
      cmd_len_c = (ni.cmd_len > MAXLEN_L) ? MAXLEN_L : ni.cmd_len;
      head_c = '0;
      head_c[TL +: 2]     = (cmd_len_c == 3'd0) ? FLIT_SINGLE : FLIT_HEAD;
      head_c[0 +: MM]     = ni.cmd_dx;
      head_c[DY +: MM]    = ni.cmd_dy;
      head_c[LN +: LEN_W] = cmd_len_c;
   end

   assign body_last = (cnt_q == len_q - 3'd1);
   assign body_xfer = (tx_state == TX_BODY) && ni.tx_valid && ni.inj_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
      end else begin
         tx_state <= tx_next;
      end
   end

   // Body flits pass straight through, so stability under stall relies on the core holding tx_data.
   always_comb begin
      tx_next      = tx_state;
      ni.cmd_ready = 1'b0;
      ni.inj_en    = 1'b0;
      ni.inj_data  = '0;
      ni.tx_ready  = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            ni.cmd_ready = 1'b1;
            if (ni.cmd_valid) begin
               tx_next = TX_HEAD;
            end
         end
         TX_HEAD: begin
            ni.inj_en   = 1'b1;
            ni.inj_data = head_q;
            if (ni.inj_ready) begin
               tx_next = (len_q == 3'd0) ? TX_IDLE : TX_BODY;
            end
         end
         TX_BODY: begin
            ni.inj_en   = ni.tx_valid;
            ni.tx_ready = ni.inj_ready;
            ni.inj_data = {(body_last ? FLIT_TAIL : FLIT_BODY), ni.tx_data};
            if (body_xfer && body_last) begin
               tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q  <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else if (tx_state == TX_IDLE && ni.cmd_valid) begin
         len_q  <= cmd_len_c;
         cnt_q  <= '0;
         head_q <= head_c;
      end else if (body_xfer) begin
         cnt_q <= cnt_q + 3'd1;
      end
   end

   // ---------------- RX ----------------
   rx_state_t     rx_state, rx_next;
   logic          ans_q, fifo_wr, fifo_rd, fifo_full, fifo_empty, err_set;
   logic [LL-1:0] front;
   logic [1:0]    front_type;

   // ans_q blocks the cycle right after an accept, when the router has not yet dropped its req.
   assign fifo_wr    = ni.ej_req && !fifo_full && !ans_q;
   assign ni.ej_ans  = ans_q;
   assign front_type = front[TL +: 2];

   always_ff @(posedge clk) begin
      if (reset) begin
         ans_q <= 1'b0;
      end else begin
         ans_q <= fifo_wr;
      end
   end

   ni_eject_fifo #(
      .W     (LL),
      .DEPTH (FDEPTH)
   ) u_eject_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fifo_wr),
      .wr_data (ni.ej_data),
      .rd_en   (fifo_rd),
      .rd_data (front),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_WAIT_HEAD;
      end else begin
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next     = rx_state;
      fifo_rd     = 1'b0;
      err_set     = 1'b0;
      ni.rx_valid = 1'b0;
      ni.rx_last  = 1'b0;
      ni.rx_data  = front[LL-3:0];
      if (!fifo_empty) begin
         case (front_type)
            FLIT_HEAD, FLIT_SINGLE: begin
               fifo_rd = 1'b1;
               err_set = (front[0 +: MM] != my_x) || (front[DY +: MM] != my_y);
               rx_next = (front_type == FLIT_HEAD) ? RX_IN_PKT : RX_WAIT_HEAD;
            end
            default: begin
               if (rx_state == RX_WAIT_HEAD) begin
                  fifo_rd = 1'b1;
                  err_set = 1'b1;
               end else begin
                  ni.rx_valid = 1'b1;
                  ni.rx_last  = (front_type == FLIT_TAIL);
                  fifo_rd     = ni.rx_ready;
                  if (ni.rx_ready && front_type == FLIT_TAIL) begin
                     rx_next = RX_WAIT_HEAD;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_misroute <= 1'b0;
      end else if (err_set) begin
         err_misroute <= 1'b1;
      end
   end

endmodule
